// File: rtl/alu_mdu.sv
// Single-cycle ALU with a multi-cycle multiply/divide unit writing HI/LO.
// The multiply is shift-add and the divide is restoring, one bit per cycle on operand magnitudes.
module alu_mdu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] op_1,
  input  logic [WIDTH-1:0] op_2,
  input  logic [3:0]       alu_ctrl,
  input  logic             start,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero_alu,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned PW    = 2 * WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULT  = 4'b1000;
  localparam logic [3:0] OP_DIV   = 4'b1010;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MFHI  = 4'b1101;
  localparam logic [3:0] OP_MFLO  = 4'b1110;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             is_div_q, is_div_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             is_seq, is_signed, s1, s2;
  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [WIDTH:0]   acc_step;
  logic [WIDTH-1:0] mq_step;
  logic [PW-1:0]    prod, prod_s;
  logic [WIDTH-1:0] quo_s, rem_s;

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

  // Combinational ALU; MFHI/MFLO expose the registers even mid-operation
  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      OP_AND:  alu_result = op_1 & op_2;
      OP_OR:   alu_result = op_1 | op_2;
      OP_ADD:  alu_result = op_1 + op_2;
      OP_SUB:  alu_result = op_1 - op_2;
      OP_SLT:  alu_result = WIDTH'($signed(op_1) < $signed(op_2));
      OP_NOR:  alu_result = ~(op_1 | op_2);
      OP_MFHI: alu_result = hi_q;
      OP_MFLO: alu_result = lo_q;
      default: alu_result = '0;
    endcase
  end

  assign zero_alu = ~|alu_result;

  // Operand capture: signed ops work on magnitudes, signs are reapplied at the end
  always_comb begin
    is_seq    = (alu_ctrl[3:2] == 2'b10);
    is_signed = (alu_ctrl == OP_MULT) || (alu_ctrl == OP_DIV);
    s1        = is_signed & op_1[WIDTH-1];
    s2        = is_signed & op_2[WIDTH-1];
    mag1      = s1 ? -op_1 : op_1;
    mag2      = s2 ? -op_2 : op_2;
  end

  // One multiply or divide iteration; the remainder never exceeds WIDTH bits so acc_q[WIDTH] stays 0
  always_comb begin
    mul_sum   = {1'b0, acc_q[WIDTH-1:0]} + (mq_q[0] ? {1'b0, b_q} : '0);
    div_shift = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    if (is_div_q) begin
      if (!div_diff[WIDTH]) begin
        acc_step = div_diff;
        mq_step  = {mq_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_step = div_shift;
        mq_step  = {mq_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_step = {1'b0, mul_sum[WIDTH:1]};
      mq_step  = {mul_sum[0], mq_q[WIDTH-1:1]};
    end
    prod   = {acc_step[WIDTH-1:0], mq_step};
    prod_s = neg_lo_q ? -prod : prod;
    quo_s  = div0_q ? '1 : (neg_lo_q ? -mq_step : mq_step);
    rem_s  = neg_hi_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    b_d      = b_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start && is_seq) begin
          state_d  = S_RUN;
          busy_d   = 1'b1;
          cnt_d    = CNT_W'(WIDTH);
          acc_d    = '0;
          mq_d     = mag1;
          b_d      = mag2;
          is_div_d = alu_ctrl[1];
          neg_lo_d = s1 ^ s2;
          neg_hi_d = s1;
          div0_d   = (op_2 == '0);
        end
      end
      S_RUN: begin
        busy_d = 1'b1;
        acc_d  = acc_step;
        mq_d   = mq_step;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (is_div_q) begin
            hi_d = rem_s;
            lo_d = quo_s;
          end else begin
            hi_d = prod_s[PW-1:WIDTH];
            lo_d = prod_s[WIDTH-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      b_q      <= b_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: combinational ops, multiply/divide results, latency, reset and chaining.
module tb_alu_mdu;

  localparam int unsigned W = 32;
  localparam logic [3:0] C_ADD   = 4'b0010;
  localparam logic [3:0] C_MULT  = 4'b1000;
  localparam logic [3:0] C_MULTU = 4'b1001;
  localparam logic [3:0] C_DIV   = 4'b1010;
  localparam logic [3:0] C_DIVU  = 4'b1011;
  localparam logic [3:0] C_MFHI  = 4'b1101;
  localparam logic [3:0] C_MFLO  = 4'b1110;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] op_1, op_2;
  logic [3:0]   alu_ctrl;
  logic         start;
  logic [W-1:0] alu_result;
  logic         zero_alu, busy, done;
  logic [W-1:0] hi, lo;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [63:0]   sb[$];

  alu_mdu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .op_1(op_1), .op_2(op_2), .alu_ctrl(alu_ctrl),
    .start(start), .alu_result(alu_result), .zero_alu(zero_alu),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] pa, pb;
    logic signed [31:0] sa, sbv, q, r;
    model = '0;
    sa  = $signed(a);
    sbv = $signed(b);
    case (c)
      C_MULT: begin
        pa = $signed({{32{a[31]}}, a});
        pb = $signed({{32{b[31]}}, b});
        model = pa * pb;
      end
      C_MULTU: model = {32'h0, a} * {32'h0, b};
      C_DIV: begin
        if (b == 32'h0) model = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = {32'h0, 32'h8000_0000};
        else begin
          q = sa / sbv;
          r = sa % sbv;
          model = {r, q};
        end
      end
      C_DIVU: begin
        if (b == 32'h0) model = {a, 32'hFFFF_FFFF};
        else model = {a % b, a / b};
      end
      default: model = '0;
    endcase
  endfunction

  // Drive one start cycle, then scramble the operand inputs
  task automatic launch(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    op_1 = a; op_2 = b; alu_ctrl = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op_1 = $urandom; op_2 = $urandom; alu_ctrl = 4'b0011;
  endtask

  // Cycles counted from the start edge; -1 when done never rises within the budget
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) cyc = -1;
  endtask

  task automatic test_reset();
    int cyc;
    logic [63:0] exp;
    rst = 1'b1; start = 1'b0; op_1 = '0; op_2 = '0; alu_ctrl = '0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({busy, done, hi, lo} !== 66'h0) begin
      n_fail++;
      $display("FAIL reset_state busy=%b done=%b hi=%h lo=%h, expected all zero", busy, done, hi, lo);
    end
    op_1 = 32'd3; op_2 = 32'd4; alu_ctrl = C_MULTU; start = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_in_reset busy=%b, expected 0", busy);
    end
    rst = 1'b0;
    sb.push_back(64'd12);
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL first_start_after_reset busy=%b, expected 1", busy);
    end
    wait_done(cyc);
    n_tests++;
    if (cyc != 33) begin
      n_fail++;
      $display("FAIL reset_release_latency got %0d cycles, expected 33", cyc);
    end
    exp = sb.pop_front();
    n_tests++;
    if ({hi, lo} !== exp) begin
      n_fail++;
      $display("FAIL reset_release_result hi:lo=%h, expected %h", {hi, lo}, exp);
    end
  endtask

  task automatic test_comb();
    logic [3:0]  c[13];
    logic [31:0] a[13], b[13], e[13];
    c = '{C_ADD, 4'b0110, 4'b1100, 4'b0111, 4'b0111, 4'b0011, 4'b0000, 4'b0001,
          C_ADD, 4'b0110, C_MULT, 4'b1111, C_MFLO};
    a = '{32'd7, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd12, 32'hF0F0_1234, 32'h0F0F_0000,
          32'hFFFF_FFFF, 32'd0, 32'd5, 32'd9, 32'd1};
    b = '{32'd5, 32'd5, 32'd0, 32'd1, 32'hFFFF_FFFF, 32'd34, 32'hFF00_FF00, 32'h0000_00F0,
          32'd1, 32'd1, 32'd6, 32'd9, 32'd2};
    e = '{32'd12, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'hF000_1200, 32'h0F0F_00F0,
          32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd12};
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      alu_ctrl = c[i]; op_1 = a[i]; op_2 = b[i];
      #1;
      n_tests++;
      if (alu_result !== e[i]) begin
        n_fail++;
        $display("FAIL comb_result[%0d] ctrl=%b got %h, expected %h", i, c[i], alu_result, e[i]);
      end
      n_tests++;
      if (zero_alu !== (e[i] == 32'h0)) begin
        n_fail++;
        $display("FAIL comb_zero[%0d] got %b, expected %b", i, zero_alu, (e[i] == 32'h0));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_muldiv(input int sel);
    logic [3:0]  c[4];
    logic [31:0] a[4], b[4];
    logic [63:0] e[4];
    logic [63:0] exp;
    int n, cyc;
    if (sel == 0) begin
      n = 2;
      c = '{C_MULT, C_MULTU, C_MULT, C_MULT};
      a = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd0, 32'd0};
      b = '{32'd3, 32'd3, 32'd0, 32'd0};
      e = '{64'hFFFF_FFFF_FFFF_FFFA, 64'h0000_0002_FFFF_FFFA, 64'h0, 64'h0};
    end else begin
      n = 4;
      c = '{C_DIV, C_DIVU, C_DIV, C_DIV};
      a = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFF9};
      b = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0};
      e = '{64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0007_FFFF_FFFF, 64'h0000_0000_8000_0000,
            64'hFFFF_FFF9_FFFF_FFFF};
    end
    for (int i = 0; i < n; i++) begin
      sb.push_back(e[i]);
      launch(c[i], a[i], b[i]);
      n_tests++;
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL md%0d_busy[%0d] got %b, expected 1", sel, i, busy);
      end
      wait_done(cyc);
      n_tests++;
      if (cyc != 33) begin
        n_fail++;
        $display("FAIL md%0d_latency[%0d] got %0d cycles, expected 33", sel, i, cyc);
      end
      exp = sb.pop_front();
      n_tests++;
      if ({hi, lo} !== exp) begin
        n_fail++;
        $display("FAIL md%0d_result[%0d] hi:lo=%h, expected %h", sel, i, {hi, lo}, exp);
      end
      alu_ctrl = C_MFHI; #1;
      n_tests++;
      if (alu_result !== exp[63:32]) begin
        n_fail++;
        $display("FAIL md%0d_mfhi[%0d] got %h, expected %h", sel, i, alu_result, exp[63:32]);
      end
      alu_ctrl = C_MFLO; #1;
      n_tests++;
      if (alu_result !== exp[31:0]) begin
        n_fail++;
        $display("FAIL md%0d_mflo[%0d] got %h, expected %h", sel, i, alu_result, exp[31:0]);
      end
      @(negedge clk);
      n_tests++;
      if (done !== 1'b0) begin
        n_fail++;
        $display("FAIL md%0d_done_pulse[%0d] done=%b one cycle later, expected 0", sel, i, done);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0]  c;
    logic [31:0] a, b;
    logic [63:0] exp;
    int cyc;
    for (int i = 0; i < 12; i++) begin
      c = C_MULT + 4'($urandom_range(0, 3));
      a = $urandom;
      b = (i % 4 == 3) ? 32'h0 : $urandom;
      if (i % 3 == 1) b = b >> 20;
      sb.push_back(model(c, a, b));
      launch(c, a, b);
      wait_done(cyc);
      exp = sb.pop_front();
      n_tests++;
      if (cyc != 33 || {hi, lo} !== exp) begin
        n_fail++;
        $display("FAIL random[%0d] ctrl=%b a=%h b=%h cycles=%0d hi:lo=%h, expected 33 and %h",
                 i, c, a, b, cyc, {hi, lo}, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midrun();
    logic saw_done;
    logic [63:0] exp;
    int cyc;
    saw_done = 1'b0;
    launch(C_MULTU, 32'd3, 32'd4);
    for (int k = 1; k < 10; k++) begin
      if (done) saw_done = 1'b1;
      if (k == 5) begin
        op_1 = 32'd9; op_2 = 32'd3; alu_ctrl = C_DIVU; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (k == 6) begin
        n_tests++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL ignored_start_busy got %b, expected 1", busy);
        end
      end
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({busy, done, hi, lo} !== 66'h0) begin
      n_fail++;
      $display("FAIL midrun_reset busy=%b done=%b hi=%h lo=%h, expected all zero", busy, done, hi, lo);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    n_tests++;
    if (saw_done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_discard saw_done=%b busy=%b, expected 0 0", saw_done, busy);
    end
    sb.push_back(64'd12);
    launch(C_MULTU, 32'd3, 32'd4);
    wait_done(cyc);
    exp = sb.pop_front();
    n_tests++;
    if (cyc != 33 || {hi, lo} !== exp) begin
      n_fail++;
      $display("FAIL midrun_restart cycles=%0d hi:lo=%h, expected 33 and %h", cyc, {hi, lo}, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp;
    int cyc;
    sb.push_back(64'hFFFF_FFFF_FFFF_FFF1);
    launch(C_MULT, 32'hFFFF_FFFB, 32'd3);
    wait_done(cyc);
    exp = sb.pop_front();
    n_tests++;
    if (cyc != 33 || {hi, lo} !== exp) begin
      n_fail++;
      $display("FAIL b2b_first cycles=%0d hi:lo=%h, expected 33 and %h", cyc, {hi, lo}, exp);
    end
    sb.push_back({32'd2, 32'd14});
    launch(C_DIVU, 32'd100, 32'd7);
    wait_done(cyc);
    n_tests++;
    if (cyc != 33) begin
      n_fail++;
      $display("FAIL b2b_gap done pulses %0d cycles apart, expected 33", cyc);
    end
    exp = sb.pop_front();
    n_tests++;
    if ({hi, lo} !== exp) begin
      n_fail++;
      $display("FAIL b2b_second hi:lo=%h, expected %h", {hi, lo}, exp);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_comb();
    test_muldiv(0);
    test_muldiv(1);
    test_random();
    test_reset_midrun();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width in bits (even, >= 8).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 op_1  input  WIDTH  first operand.
REQ-005 op_2  input  WIDTH  second operand.
REQ-006 alu_ctrl  input  4  operation select.
REQ-007 start  input  1  launch request for a multiply/divide operation.
REQ-008 alu_result  output  WIDTH  combinational result of the current alu_ctrl.
REQ-009 zero_alu  output  1  high when alu_result is all zeros.
REQ-010 busy  output  1  multiply/divide in progress.
REQ-011 done  output  1  one-cycle pulse when hi/lo hold a new result.
REQ-012 hi  output  WIDTH  HI register: product upper half or remainder.
REQ-013 lo  output  WIDTH  LO register: product lower half or quotient.

Function
REQ-014 Combinational ops, same-cycle result: 0000 AND; 0001 OR; 0010 ADD (wraps mod 2^WIDTH); 0110 SUB (wraps); 0111 SLT, signed two's-complement compare, result 1 or 0; 1100 NOR, bitwise ~(op_1|op_2).
REQ-015 1101 MFHI drives alu_result = hi; 1110 MFLO drives alu_result = lo; these return the register contents even while busy.
REQ-016 Sequential ops: 1000 MULT (signed), 1001 MULTU, 1010 DIV (signed), 1011 DIVU; alu_result = 0 for these codes.
REQ-017 All other alu_ctrl codes give alu_result = 0.
REQ-018 zero_alu is combinationally equal to NOR-reduction of alu_result in every cycle.
REQ-019 FSM states: IDLE, RUN, DONE.
REQ-020 IDLE or DONE, start=1 with sequential alu_ctrl: capture operands and op, load counter = WIDTH, go to RUN.
REQ-021 start with a non-sequential alu_ctrl is ignored; start while in RUN is ignored.
REQ-022 RUN: one iteration per cycle (shift-add multiply or restoring divide on operand magnitudes); counter decrements; at counter reaching 0, go to DONE.
REQ-023 busy = 1 exactly in RUN; done = 1 exactly in DONE; DONE lasts one cycle and then returns to IDLE unless REQ-020 applies.
REQ-024 Latency: start sampled at edge N; busy high after edges N..N+WIDTH-1; done high and hi/lo updated after edge N+WIDTH (WIDTH+1 cycles start to done).
REQ-025 hi/lo change only on the edge entering DONE, or on reset.
REQ-026 MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product; signed sign applied after the magnitude multiply.
REQ-027 DIV/DIVU: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
REQ-028 Divide by zero: hi = dividend (op_1 as captured), lo = all ones; latency unchanged.
REQ-029 DIV of most-negative by -1: lo = most-negative value, hi = 0.
REQ-030 Operand inputs may change after the start edge without affecting the result.

Reset
REQ-031 rst high, at any time including mid-RUN: FSM -> IDLE, counter = 0, busy = 0, done = 0, hi = 0, lo = 0; the operation in flight is discarded.
REQ-032 With rst held high, start is ignored; first accepted start is on the first edge with rst low.

Verification
REQ-033 WIDTH=32: ADD 7,5 -> alu_result 12, zero_alu 0; SUB 5,5 -> 0, zero_alu 1; NOR 0,0 -> 0xFFFFFFFF.
REQ-034 SLT op_1=0xFFFFFFFF, op_2=1 -> 1; SLT op_1=1, op_2=0xFFFFFFFF -> 0; code 0011 -> 0.
REQ-035 MULT 0xFFFFFFFE,3 -> done 33 cycles after start, hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU same -> hi=0x00000002, lo=0xFFFFFFFA; MFHI/MFLO read back both.
REQ-036 DIV 0xFFFFFFF9 (-7),2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7,0 -> hi=7, lo=0xFFFFFFFF; DIV 0x80000000,0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-037 Start MULTU 3,4; assert start with DIVU 9,3 at cycle 5 (ignored); rst at cycle 10 -> busy 0, done never pulses, hi=lo=0; restarting MULTU 3,4 yields lo=12, hi=0.
REQ-038 Back-to-back: start asserted in the DONE cycle of one op launches the next; two done pulses exactly 33 cycles apart.
